cam_write_ctrl: RTL and testbench

- Write-side controller for the BRAM CAM (cam_bram); arbitrates insert/delete requests from PORTS requesters onto the CAM's single write port.
- Owns the entry-occupancy bitmap and allocates the lowest free CAM address for inserts.
- Sequences the CAM write handshake: waits on write_busy, pulses write_enable, holds address/data stable until the CAM finishes.
- Sits between the lookup-table management clients and the cam_bram instance. The CAM search side is untouched.

---
 rtl/cam_ctrl_pkg.sv | 25 ++
 rtl/cam_rr_arbiter.sv | 75 +++++++
 rtl/priority_encoder.sv | 46 ++++
 rtl/cam_write_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cam_write_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_ctrl_pkg
// Description : Shared types and constants for the CAM write-side controller:
//               controller state encoding and the response status codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_ctrl_pkg;

  // Write controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // arbitrate and accept one request
    ST_ISSUE = 3'd1,  // wait for CAM ready, pulse write enable
    ST_ARM   = 3'd2,  // CAM raises busy one cycle after enable
    ST_WAIT  = 3'd3,  // wait for CAM write to finish, commit bitmap
    ST_RESP  = 3'd4   // one-cycle completion pulse
  } cam_state_e;

  // Response status codes
  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_FULL    = 2'b01;
  localparam logic [1:0] STATUS_INVALID = 2'b10;

endpackage : cam_ctrl_pkg
`default_nettype wire

// File: rtl/cam_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cam_rr_arbiter
// Description : Round-robin arbiter. The search starts at the internal
//               pointer; when i_advance is high the pointer moves to the
//               port after the current grant.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_req            - per-port request
//               i_advance        - current grant was taken this cycle
//               o_grant          - one-hot grant (combinational)
//               o_grant_idx      - index of granted port
//               o_grant_valid    - some port is granted
// Revision    : 1.0 - initial release
// ============================================================================
module cam_rr_arbiter #(
  parameter int PORTS = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [PORTS-1:0]                             i_req,
  input  logic                                         i_advance,
  output logic [PORTS-1:0]                             o_grant,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] o_grant_idx,
  output logic                                         o_grant_valid
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [IW:0] c_ports = (IW + 1)'(PORTS);

  logic [IW-1:0]      r_ptr;
  logic [2*PORTS-1:0] w_req_dbl;
  logic [PORTS-1:0]   w_req_rot;
  logic [IW-1:0]      w_off;
  logic [IW:0]        w_sum;
  logic [IW:0]        w_ptr_sum;
  logic [IW-1:0]      w_ptr_next;

  // Rotate the request vector so the pointer position lands on bit 0;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    w_req_dbl     = {i_req, i_req};
    w_req_rot     = PORTS'(w_req_dbl >> r_ptr);
    w_off         = '0;
    o_grant_valid = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_off         = IW'(i);
        o_grant_valid = 1'b1;
      end
    end
    // Undo the rotation: index = (ptr + offset) mod PORTS
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= c_ports) w_sum = w_sum - c_ports;
    o_grant_idx = w_sum[IW-1:0];
    for (int i = 0; i < PORTS; i++) begin
      o_grant[i] = o_grant_valid && (o_grant_idx == IW'(i));
    end
  end

  always_comb begin
    w_ptr_sum = {1'b0, o_grant_idx} + (IW + 1)'(1);
    if (w_ptr_sum >= c_ports) w_ptr_next = '0;
    else                      w_ptr_next = w_ptr_sum[IW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && o_grant_valid) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule : cam_rr_arbiter
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder
// Description : Returns the index of the highest-priority set bit.
//               LSB_PRIORITY "HIGH" -> lowest set index wins,
//               otherwise the highest set index wins.
// Ports       : input_unencoded - request vector
//               output_valid    - at least one bit set
//               output_encoded  - index of winning bit (0 when none set)
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder #(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0]                             input_unencoded,
  output logic                                         output_valid,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] output_encoded
);

  localparam int EW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  assign output_valid = |input_unencoded;

  generate
    if (LSB_PRIORITY == "HIGH") begin : g_lsb_first
      // Scan downwards so the last (lowest) set bit found wins.
      always_comb begin
        output_encoded = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (input_unencoded[i]) output_encoded = EW'(i);
        end
      end
    end else begin : g_msb_first
      // Scan upwards so the last (highest) set bit found wins.
      always_comb begin
        output_encoded = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (input_unencoded[i]) output_encoded = EW'(i);
        end
      end
    end
  endgenerate

endmodule : priority_encoder
`default_nettype wire

// File: rtl/cam_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_write_ctrl
// Description : Write-side controller for the BRAM CAM. Arbitrates insert and
//               delete requests from PORTS requesters onto the single CAM
//               write port, owns the occupancy bitmap, allocates the lowest
//               free address for inserts and sequences the CAM write
//               handshake (busy / enable).
// Ports       : clk, rst_n            clock, synchronous active-low reset
//               i_req_valid/o_req_ready  per-port request / accept pulse
//               i_req_delete          1 = delete, 0 = insert
//               i_req_data            insert key, port p at [p*DATA_WIDTH +:]
//               i_req_addr            delete address, port p at [p*ADDR_WIDTH +:]
//               o_resp_*              completion pulse, port, address, status
//               o_cam_write_*         CAM write port (addr/data/delete/enable)
//               i_cam_write_busy      CAM write busy
//               o_entry_valid         occupancy bitmap
//               o_entry_count, o_full occupied entries, table full
// Revision    : 1.0 - initial release
// ============================================================================
module cam_write_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int PORTS      = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [PORTS-1:0]                             i_req_valid,
  output logic [PORTS-1:0]                             o_req_ready,
  input  logic [PORTS-1:0]                             i_req_delete,
  input  logic [PORTS*DATA_WIDTH-1:0]                  i_req_data,
  input  logic [PORTS*ADDR_WIDTH-1:0]                  i_req_addr,
  output logic                                         o_resp_valid,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] o_resp_port,
  output logic [ADDR_WIDTH-1:0]                        o_resp_addr,
  output logic [1:0]                                   o_resp_status,
  output logic [ADDR_WIDTH-1:0]                        o_cam_write_addr,
  output logic [DATA_WIDTH-1:0]                        o_cam_write_data,
  output logic                                         o_cam_write_delete,
  output logic                                         o_cam_write_enable,
  input  logic                                         i_cam_write_busy,
  output logic [2**ADDR_WIDTH-1:0]                     o_entry_valid,
  output logic [ADDR_WIDTH:0]                          o_entry_count,
  output logic                                         o_full
);

  localparam int PW      = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int ENTRIES = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_full_count = (ADDR_WIDTH + 1)'(ENTRIES);
  localparam logic [ADDR_WIDTH:0] c_count_one  = (ADDR_WIDTH + 1)'(1);

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  cam_state_e r_state;
  cam_state_e w_state_next;

  logic                  r_cap_delete;
  logic [DATA_WIDTH-1:0] r_cap_data;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic [PW-1:0]         r_cap_port;

  logic [ENTRIES-1:0]    r_entry_valid;
  logic [ADDR_WIDTH:0]   r_entry_count;

  logic [PW-1:0]         r_resp_port;
  logic [ADDR_WIDTH-1:0] r_resp_addr;
  logic [1:0]            r_resp_status;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [PORTS-1:0]      w_grant;
  logic [PW-1:0]         w_grant_idx;
  logic                  w_grant_valid;

  logic                  w_sel_delete;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [ADDR_WIDTH-1:0] w_sel_addr;

  logic                  w_free_valid;
  logic [ADDR_WIDTH-1:0] w_free_addr;

  logic                  w_accept;     // a request is taken this cycle
  logic                  w_launch;     // taken request proceeds to the CAM
  logic                  w_reject;     // taken request answered immediately
  logic [1:0]            w_reject_status;
  logic                  w_cam_we;
  logic                  w_commit;     // CAM write finished, update bitmap

  cam_rr_arbiter #(
    .PORTS (PORTS)
  ) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req_valid),
    .i_advance     (w_accept),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Lowest free entry = lowest zero bit of the occupancy bitmap.
  priority_encoder #(
    .WIDTH        (ENTRIES),
    .LSB_PRIORITY ("HIGH")
  ) u_free_enc (
    .input_unencoded (~r_entry_valid),
    .output_valid    (w_free_valid),
    .output_encoded  (w_free_addr)
  );

  // Route the granted port's request fields.
  always_comb begin
    w_sel_delete = 1'b0;
    w_sel_data   = '0;
    w_sel_addr   = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel_delete = i_req_delete[p];
        w_sel_data   = i_req_data[p*DATA_WIDTH +: DATA_WIDTH];
        w_sel_addr   = i_req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_launch        = 1'b0;
    w_reject        = 1'b0;
    w_reject_status = STATUS_OK;
    w_cam_we        = 1'b0;
    w_commit        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // rst_n gating keeps req_ready quiet while reset is held.
        if (rst_n && w_grant_valid) begin
          w_accept = 1'b1;
          if (!w_sel_delete) begin
            // No free entry is the same condition as o_full.
            if (!w_free_valid) begin
              w_reject        = 1'b1;
              w_reject_status = STATUS_FULL;
              w_state_next    = ST_RESP;
            end else begin
              w_launch     = 1'b1;
              w_state_next = ST_ISSUE;
            end
          end else if (!r_entry_valid[w_sel_addr]) begin
            w_reject        = 1'b1;
            w_reject_status = STATUS_INVALID;
            w_state_next    = ST_RESP;
          end else begin
            w_launch     = 1'b1;
            w_state_next = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // Also absorbs the CAM's init sweep after reset.
        if (!i_cam_write_busy) begin
          w_cam_we     = 1'b1;
          w_state_next = ST_ARM;
        end
      end

      // Busy is not yet visible the cycle after enable; skip checking it.
      ST_ARM: w_state_next = ST_WAIT;

      ST_WAIT: begin
        if (!i_cam_write_busy) begin
          w_commit     = 1'b1;
          w_state_next = ST_RESP;
        end
      end

      ST_RESP: w_state_next = ST_IDLE;

      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request capture, occupancy bitmap, response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap_delete  <= 1'b0;
      r_cap_data    <= '0;
      r_cap_addr    <= '0;
      r_cap_port    <= '0;
      r_entry_valid <= '0;
      r_entry_count <= '0;
      r_resp_port   <= '0;
      r_resp_addr   <= '0;
      r_resp_status <= STATUS_OK;
    end else begin
      // The CAM write fields only change when a new write is launched, so
      // they stay stable from ISSUE through WAIT.
      if (w_launch) begin
        r_cap_delete <= w_sel_delete;
        r_cap_data   <= w_sel_data;
        r_cap_addr   <= w_sel_delete ? w_sel_addr : w_free_addr;
        r_cap_port   <= w_grant_idx;
      end

      if (w_reject) begin
        r_resp_port   <= w_grant_idx;
        r_resp_addr   <= w_sel_delete ? w_sel_addr : '0;
        r_resp_status <= w_reject_status;
      end

      if (w_commit) begin
        if (r_cap_delete) begin
          r_entry_valid[r_cap_addr] <= 1'b0;
          r_entry_count             <= r_entry_count - c_count_one;
        end else begin
          r_entry_valid[r_cap_addr] <= 1'b1;
          r_entry_count             <= r_entry_count + c_count_one;
        end
        r_resp_port   <= r_cap_port;
        r_resp_addr   <= r_cap_addr;
        r_resp_status <= STATUS_OK;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_req_ready        = w_grant & {PORTS{w_accept}};
  assign o_resp_valid       = (r_state == ST_RESP);
  assign o_resp_port        = r_resp_port;
  assign o_resp_addr        = r_resp_addr;
  assign o_resp_status      = r_resp_status;
  assign o_cam_write_addr   = r_cap_addr;
  assign o_cam_write_data   = r_cap_data;
  assign o_cam_write_delete = r_cap_delete;
  assign o_cam_write_enable = w_cam_we;
  assign o_entry_valid      = r_entry_valid;
  assign o_entry_count      = r_entry_count;
  assign o_full             = (r_entry_count == c_full_count);

endmodule : cam_write_ctrl
`default_nettype wire

// File: tb/tb_cam_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_write_ctrl
// Description : Directed self-checking bench for cam_write_ctrl with a
//               behavioural CAM write port (busy for BUSY_LEN cycles after
//               each enable, plus a forced busy window modelling init sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_write_ctrl;

  localparam int DW       = 64;
  localparam int AW       = 2;
  localparam int P        = 2;
  localparam int N        = 4;
  localparam int BUSY_LEN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [P-1:0]    req_valid, req_ready, req_delete;
  logic [P*DW-1:0] req_data;
  logic [P*AW-1:0] req_addr;
  logic            resp_valid;
  logic [0:0]      resp_port;
  logic [AW-1:0]   resp_addr;
  logic [1:0]      resp_status;
  logic [AW-1:0]   cam_addr;
  logic [DW-1:0]   cam_data;
  logic            cam_del, cam_en, cam_busy;
  logic [N-1:0]    entry_valid;
  logic [AW:0]     entry_count;
  logic            full;

  cam_write_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PORTS(P)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_delete       (req_delete),
    .i_req_data         (req_data),
    .i_req_addr         (req_addr),
    .o_resp_valid       (resp_valid),
    .o_resp_port        (resp_port),
    .o_resp_addr        (resp_addr),
    .o_resp_status      (resp_status),
    .o_cam_write_addr   (cam_addr),
    .o_cam_write_data   (cam_data),
    .o_cam_write_delete (cam_del),
    .o_cam_write_enable (cam_en),
    .i_cam_write_busy   (cam_busy),
    .o_entry_valid      (entry_valid),
    .o_entry_count      (entry_count),
    .o_full             (full)
  );

  // ---------------- behavioural CAM write port ----------------
  logic          force_busy = 1'b1;
  int            busy_cnt   = 0;
  int            n_en       = 0;
  logic [DW-1:0] cam_mem [N] = '{default: '0};

  assign cam_busy = force_busy | (busy_cnt != 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (cam_en === 1'b1) begin
        n_en     <= n_en + 1;
        busy_cnt <= BUSY_LEN;
        if (!cam_del) cam_mem[cam_addr] <= cam_data;
      end
    end
  end

  // ---------------- checking infrastructure ----------------
  int errors = 0;
  int checks = 0;

  logic          hold_en = 1'b0;
  logic [AW-1:0] hold_addr;
  logic          hold_del;
  int            hold_bad = 0;
  int            hold_samples = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request on port p; returns once accepted (at accept+1 cycle).
  task automatic present(input int p, input logic del, input logic [63:0] d,
                         input logic [AW-1:0] a, output bit acc, output int wcyc);
    req_valid[p]          = 1'b1;
    req_delete[p]         = del;
    req_data[p*DW +: DW]  = d;
    req_addr[p*AW +: AW]  = a;
    acc  = 1'b0;
    wcyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (!acc) begin
        #1;
        if (req_ready[p] === 1'b1) acc = 1'b1;
        else                        wcyc++;
        @(posedge clk);
        #1;
      end
    end
    req_valid[p] = 1'b0;
  endtask

  // Wait for resp_valid; lat counts cycles since the accept cycle.
  task automatic wait_resp(input int budget, output bit got, output int lat);
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < budget; i++) begin
      if (!got) begin
        if (resp_valid === 1'b1) begin
          got = 1'b1;
        end else begin
          if (hold_en && cam_busy) begin
            hold_samples++;
            if (cam_addr !== hold_addr || cam_del !== hold_del) hold_bad++;
          end
          tick();
          lat++;
        end
      end
    end
  endtask

  // Full transaction; leaves the bench one cycle after the response.
  task automatic txn(input string tag, input int p, input logic del,
                     input logic [63:0] d, input logic [AW-1:0] a,
                     output logic [1:0] st, output logic [AW-1:0] ad,
                     output logic pt, output int lat);
    bit acc, got;
    int wcyc;
    present(p, del, d, a, acc, wcyc);
    check({tag, "_accept"}, 64'(acc), 64'd1);
    wait_resp(40, got, lat);
    check({tag, "_resp_seen"}, 64'(got), 64'd1);
    st = resp_status;
    ad = resp_addr;
    pt = resp_port[0];
    tick();
  endtask

  task automatic do_reset(input int busy_cycles);
    rst_n      = 1'b0;
    force_busy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (busy_cycles) tick();
    force_busy = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0]    st;
    logic [AW-1:0] ad;
    logic          pt;
    int            lat, wcyc, en0;
    bit            acc, got;
    int            glog [4];
    int            rport [4];
    int            raddr [4];
    int            gn, rn, idx0, idx1;
    bit            upd0, upd1;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_delete = '0;
    req_data   = '0;
    req_addr   = '0;
    force_busy = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_entry_valid", 64'(entry_valid), 64'd0);
    check("rst_entry_count", 64'(entry_count), 64'd0);
    check("rst_full",        64'(full),        64'd0);
    check("rst_resp_valid",  64'(resp_valid),  64'd0);
    check("rst_cam_fields",  64'({cam_en, cam_del, cam_addr}), 64'd0);
    check("rst_cam_data",    cam_data, 64'd0);

    // 1: insert during a long CAM busy window
    rst_n = 1'b1;
    present(0, 1'b0, 64'hAB, '0, acc, wcyc);
    check("t1_accept", 64'(acc), 64'd1);
    check("t1_accept_immediate", 64'(wcyc), 64'd0);
    repeat (600) tick();
    check("t1_no_enable_while_busy", 64'(n_en), 64'd0);
    check("t1_cam_data_held", cam_data, 64'hAB);
    force_busy = 1'b0;
    wait_resp(20, got, lat);
    check("t1_resp_seen", 64'(got), 64'd1);
    check("t1_resp_addr",   64'(resp_addr),   64'd0);
    check("t1_resp_status", 64'(resp_status), 64'd0);
    check("t1_resp_port",   64'(resp_port),   64'd0);
    check("t1_entry_valid", 64'(entry_valid), 64'b0001);
    check("t1_enables",     64'(n_en),        64'd1);
    tick();

    // 2: fill the table, then overflow
    do_reset(10);
    check("t2_cleared", 64'(entry_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      txn("t2_ins", 0, 1'b0, 64'(k + 1), '0, st, ad, pt, lat);
      check("t2_ins_addr",   64'(ad), 64'(k));
      check("t2_ins_status", 64'(st), 64'd0);
      if (k == 0) check("t2_latency", 64'(lat), 64'(2 + BUSY_LEN + 1));
    end
    check("t2_count", 64'(entry_count), 64'd4);
    check("t2_full",  64'(full),        64'd1);
    check("t2_valid", 64'(entry_valid), 64'hF);
    en0 = n_en;
    txn("t2_ovf", 0, 1'b0, 64'h5, '0, st, ad, pt, lat);
    check("t2_ovf_status",  64'(st),          64'd1);
    check("t2_ovf_addr",    64'(ad),          64'd0);
    check("t2_ovf_latency", 64'(lat),         64'd1);
    check("t2_ovf_no_en",   64'(n_en),        64'(en0));
    check("t2_ovf_count",   64'(entry_count), 64'd4);

    // 3: delete addr 2 from full, then reinsert
    hold_en      = 1'b1;
    hold_addr    = 2'd2;
    hold_del     = 1'b1;
    hold_bad     = 0;
    hold_samples = 0;
    txn("t3_del", 0, 1'b1, 64'h0, 2'd2, st, ad, pt, lat);
    hold_en = 1'b0;
    check("t3_hold_stable",  64'(hold_bad), 64'd0);
    check("t3_hold_sampled", 64'(hold_samples >= 2), 64'd1);
    check("t3_del_status",   64'(st),          64'd0);
    check("t3_del_addr",     64'(ad),          64'd2);
    check("t3_valid",        64'(entry_valid), 64'b1011);
    check("t3_count",        64'(entry_count), 64'd3);
    txn("t3_ins", 0, 1'b0, 64'h9, '0, st, ad, pt, lat);
    check("t3_ins_addr", 64'(ad), 64'd2);
    check("t3_ins_mem",  cam_mem[2], 64'h9);

    // 4: delete on empty table from port 1
    do_reset(10);
    en0 = n_en;
    txn("t4_del", 1, 1'b1, 64'h0, 2'd1, st, ad, pt, lat);
    check("t4_status",  64'(st),          64'd2);
    check("t4_latency", 64'(lat),         64'd1);
    check("t4_port",    64'(pt),          64'd1);
    check("t4_addr",    64'(ad),          64'd1);
    check("t4_no_en",   64'(n_en),        64'(en0));
    check("t4_count",   64'(entry_count), 64'd0);

    // 5: both ports continuously requesting inserts
    gn = 0; rn = 0; idx0 = 0; idx1 = 0; upd0 = 0; upd1 = 0;
    req_delete = '0;
    req_data[0 +: DW]  = 64'h10;
    req_data[DW +: DW] = 64'h20;
    req_valid = 2'b11;
    for (int c = 0; c < 200; c++) begin
      if (rn < 4) begin
        #1;
        if (req_ready[0] === 1'b1) begin if (gn < 4) glog[gn] = 0; gn++; upd0 = 1; end
        if (req_ready[1] === 1'b1) begin if (gn < 4) glog[gn] = 1; gn++; upd1 = 1; end
        if (resp_valid === 1'b1) begin
          if (rn < 4) begin rport[rn] = int'(resp_port); raddr[rn] = int'(resp_addr); end
          rn++;
        end
        @(posedge clk);
        #1;
        if (upd0) begin
          idx0++; upd0 = 0;
          if (idx0 < 2) req_data[0 +: DW] = 64'h11; else req_valid[0] = 1'b0;
        end
        if (upd1) begin
          idx1++; upd1 = 0;
          if (idx1 < 2) req_data[DW +: DW] = 64'h21; else req_valid[1] = 1'b0;
        end
      end
    end
    req_valid = '0;
    check("t5_grants", 64'(gn), 64'd4);
    check("t5_resps",  64'(rn), 64'd4);
    if (gn == 4 && rn == 4) begin
      check("t5_grant_order", 64'({glog[0][0], glog[1][0], glog[2][0], glog[3][0]}), 64'b0101);
      check("t5_resp_ports",  64'({rport[0][0], rport[1][0], rport[2][0], rport[3][0]}), 64'b0101);
      check("t5_resp_addrs",  64'({raddr[0][1:0], raddr[1][1:0], raddr[2][1:0], raddr[3][1:0]}), 64'b00_01_10_11);
    end
    check("t5_mem0", cam_mem[0], 64'h10);
    check("t5_mem1", cam_mem[1], 64'h20);
    check("t5_mem2", cam_mem[2], 64'h11);
    check("t5_mem3", cam_mem[3], 64'h21);
    check("t5_valid", 64'(entry_valid), 64'hF);
    tick();

    // 6: reset while a write is in WAIT, then re-present
    txn("t6_del", 0, 1'b1, 64'h0, 2'd3, st, ad, pt, lat);
    check("t6_del_status", 64'(st), 64'd0);
    present(0, 1'b0, 64'h55, '0, acc, wcyc);   // now at accept+1 (ISSUE)
    check("t6_accept", 64'(acc), 64'd1);
    check("t6_target", 64'(cam_addr), 64'd3);
    tick();                                    // ARM
    tick();                                    // WAIT
    rst_n      = 1'b0;
    force_busy = 1'b1;
    tick();
    check("t6_rst_count", 64'(entry_count), 64'd0);
    check("t6_rst_valid", 64'(entry_valid), 64'd0);
    check("t6_rst_outs",  64'({resp_valid, cam_en, cam_del, full, cam_addr}), 64'd0);
    check("t6_rst_data",  cam_data, 64'd0);
    rst_n = 1'b1;
    present(0, 1'b0, 64'h55, '0, acc, wcyc);
    check("t6_re_accept_immediate", 64'(wcyc), 64'd0);
    repeat (15) tick();
    force_busy = 1'b0;
    wait_resp(30, got, lat);
    check("t6_resp_seen",   64'(got),         64'd1);
    check("t6_resp_status", 64'(resp_status), 64'd0);
    check("t6_resp_addr",   64'(resp_addr),   64'd0);
    check("t6_valid",       64'(entry_valid), 64'b0001);
    check("t6_count",       64'(entry_count), 64'd1);
    check("t6_mem0",        cam_mem[0],       64'h55);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule : tb_cam_write_ctrl
`default_nettype wire
